// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the debug/console UART: default clocking and line
//   rate, 8N1 frame constants, and the receiver state encoding. Imported by
//   the receiver, its baud tick generator and the existing transmitter.
// ---------------------------------------------------------------------------
package uart_pkg;

  // Default system clock, line rate and oversampling factor
  localparam int CLK_HZ_DEF = 100_000_000;
  localparam int BAUD_DEF   = 115_200;
  localparam int OVS_DEF    = 16;

  // Frame format: 1 start bit, DATA_BITS data bits LSB-first, STOP_BITS stop
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } uart_rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
//   Fractional oversampling tick generator. Every clock the accumulator adds
//   BAUD*OVS; when it reaches CLK_HZ it wraps by subtracting CLK_HZ and emits
//   a one-cycle tick. The remainder carries over, so the mean tick period is
//   exactly CLK_HZ/(BAUD*OVS) cycles with no long-term drift.
//
// Ports
//   sys_clk_i   in   system clock
//   sys_rstn_i  in   asynchronous active-low reset
//   clr_i       in   synchronous clear of the accumulator (phase alignment)
//   tick_o      out  one-cycle pulse at BAUD*OVS average rate
// ---------------------------------------------------------------------------
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEF,
  parameter int BAUD   = BAUD_DEF,
  parameter int OVS    = OVS_DEF
) (
  input  logic sys_clk_i,
  input  logic sys_rstn_i,
  input  logic clr_i,
  output logic tick_o
);

  // acc stays below CLK_HZ, so acc + increment stays below CLK_HZ + BAUD*OVS;
  // 27 bits for the 100 MHz / 115200 / 16 configuration.
  localparam int ACC_W = $clog2(CLK_HZ + BAUD * OVS);

  localparam logic [ACC_W-1:0] ACC_INC = ACC_W'(BAUD * OVS);
  localparam logic [ACC_W-1:0] ACC_LIM = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] r_acc;
  logic             r_tick;
  logic [ACC_W-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + ACC_INC;

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else if (clr_i) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else if (w_acc_nxt >= ACC_LIM) begin
      r_acc  <= w_acc_nxt - ACC_LIM;
      r_tick <= 1'b1;
    end else begin
      r_acc  <= w_acc_nxt;
      r_tick <= 1'b0;
    end
  end

  assign tick_o = r_tick;

endmodule : uart_baud_tick

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1 serial receiver with OVS-times oversampling and mid-bit sampling.
//   The asynchronous line is synchronised, a falling edge in IDLE starts a
//   frame and re-phases the tick generator, the start bit is re-checked at
//   its middle (glitch rejection), data bits are sampled every OVS ticks
//   after that, and the stop bit decides between a valid byte and a framing
//   error. The FSM returns to IDLE at mid-stop-bit so back-to-back frames are
//   not lost.
//
// Ports
//   sys_clk_i         in   system clock
//   sys_rstn_i        in   asynchronous active-low reset
//   uart_rx_i         in   serial line, asynchronous, idle high
//   uart_dat_o        out  last good byte, held until the next good byte
//   uart_valid_o      out  one-cycle pulse, uart_dat_o just updated
//   uart_frame_err_o  out  one-cycle pulse, stop bit sampled low
//   uart_busy_o       out  high while a frame is being received
//
// States
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   RX_IDLE   | line idle, waiting for a falling edge on the synchronised rx
//   RX_START  | counting to mid start bit, then confirm low or reject glitch
//   RX_DATA   | sampling DATA_BITS data bits at their middles, LSB first
//   RX_STOP   | sampling stop bit(s) at their middles, then report
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEF,
  parameter int BAUD   = BAUD_DEF,
  parameter int OVS    = OVS_DEF
) (
  input  logic       sys_clk_i,
  input  logic       sys_rstn_i,
  input  logic       uart_rx_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  output logic       uart_frame_err_o,
  output logic       uart_busy_o
);

  localparam int TW = $clog2(OVS);

  // Tick counter terminal values: OVS/2 ticks reach mid start bit, OVS ticks
  // step from one bit middle to the next.
  localparam logic [TW-1:0] T_HALF_LAST = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_FULL_LAST = TW'(OVS - 1);

  localparam logic [2:0] B_DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] B_STOP_LAST = 3'(STOP_BITS - 1);

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rx_s;
  logic r_rx_d;
  logic w_fall;

  // Flops reset to the idle level so release of reset never looks like a
  // start edge.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx_i;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  assign w_fall = r_rx_d & ~r_rx_s;

  // -------------------------------------------------------------------------
  // Tick generator, phase-aligned to the detected start edge
  // -------------------------------------------------------------------------
  uart_rx_state_t r_state;
  logic           w_tick;
  logic           w_tick_clr;

  assign w_tick_clr = (r_state == RX_IDLE) && w_fall;

  uart_baud_tick #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .OVS    (OVS)
  ) u_baud_tick (
    .sys_clk_i  (sys_clk_i),
    .sys_rstn_i (sys_rstn_i),
    .clr_i      (w_tick_clr),
    .tick_o     (w_tick)
  );

  // -------------------------------------------------------------------------
  // Receive FSM with registered outputs
  // -------------------------------------------------------------------------
  logic [TW-1:0] r_tcnt;
  logic [2:0]    r_bcnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_dat;
  logic          r_valid;
  logic          r_frame_err;
  logic          r_busy;

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      r_state     <= RX_IDLE;
      r_tcnt      <= '0;
      r_bcnt      <= '0;
      r_shift     <= '0;
      r_dat       <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        RX_IDLE: begin
          if (w_fall) begin
            r_state <= RX_START;
            r_tcnt  <= '0;
            r_busy  <= 1'b1;
          end
        end

        RX_START: begin
          if (w_tick) begin
            if (r_tcnt == T_HALF_LAST) begin
              if (!r_rx_s) begin
                r_state <= RX_DATA;
                r_tcnt  <= '0;
                r_bcnt  <= '0;
              end else begin
                // Line already back high at mid start bit: treat as noise.
                r_state <= RX_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end

        RX_DATA: begin
          if (w_tick) begin
            if (r_tcnt == T_FULL_LAST) begin
              r_tcnt  <= '0;
              r_shift <= {r_rx_s, r_shift[7:1]};
              if (r_bcnt == B_DATA_LAST) begin
                r_bcnt  <= '0;
                r_state <= RX_STOP;
              end else begin
                r_bcnt <= r_bcnt + 1'b1;
              end
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end

        RX_STOP: begin
          if (w_tick) begin
            if (r_tcnt == T_FULL_LAST) begin
              r_tcnt <= '0;
              if (!r_rx_s) begin
                r_frame_err <= 1'b1;
                r_state     <= RX_IDLE;
                r_busy      <= 1'b0;
              end else if (r_bcnt == B_STOP_LAST) begin
                // Leave at mid stop bit so a following start edge is caught.
                r_dat   <= r_shift;
                r_valid <= 1'b1;
                r_state <= RX_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_bcnt <= r_bcnt + 1'b1;
              end
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end

        default: begin
          r_state <= RX_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_dat_o       = r_dat;
  assign uart_valid_o     = r_valid;
  assign uart_frame_err_o = r_frame_err;
  assign uart_busy_o      = r_busy;

endmodule : uart_rx
